// File: rtl/anton_neopixel_sequencer.sv
// anton_neopixel_sequencer
// Timing/state sequencer feeding the NeoPixel bit-stream output stage.
// A prescaler turns the system clock into pattern-slot ticks. Each tick
// advances the slot/bit/pixel indices while transmitting. After a frame
// the line is held in the reset/latch state for RESET_TICKS slots.
// Optional feature macro: NEOPIXEL_FRAME_COUNTER_EN (16-bit completed-frame
// counter; without it frameCount is tied to zero).
// BUFFER_BITS must be at least 3 so the 32-bit pixel alignment bits exist.

`ifndef BUFFER_END_DEFAULT
`define BUFFER_END_DEFAULT 47
`endif
`ifndef ENUM_STATE_RESET
`define ENUM_STATE_RESET 1'b0
`endif
`ifndef ENUM_STATE_TRANSMIT
`define ENUM_STATE_TRANSMIT 1'b1
`endif
`ifndef CLOG2
`define CLOG2(x) $clog2(x)
`endif

module anton_neopixel_sequencer #(
  parameter int BUFFER_END  = `BUFFER_END_DEFAULT,
  parameter int CLK_DIVIDER = 5,
  parameter int RESET_TICKS = 400,
  localparam int BUFFER_BITS = `CLOG2(BUFFER_END + 1)
) (
  input  logic                   clk,
  input  logic                   syncReset,
  input  logic                   regCtrlRun,
  input  logic                   regCtrlLoop,
  input  logic                   regCtrl32bit,
  input  logic [BUFFER_BITS-1:0] regCtrlLimit,
  output logic                   state,
  output logic [BUFFER_BITS-1:0] pixelIndex,
  output logic [4:0]             pixelBitIndex,
  output logic [2:0]             bitPatternIndex,
  output logic                   frameDone,
  output logic [15:0]            frameCount
);

  typedef enum logic {
    stReset    = `ENUM_STATE_RESET,
    stTransmit = `ENUM_STATE_TRANSMIT
  } seqState_t;

  localparam int RC_BITS = $clog2(RESET_TICKS + 1);
  localparam logic [RC_BITS-1:0]     RC_LAST  = RC_BITS'(RESET_TICKS - 1);
  localparam logic [7:0]             DIV_LAST = 8'(CLK_DIVIDER - 1);
  localparam logic [BUFFER_BITS:0]   END_W    = (BUFFER_BITS + 1)'(BUFFER_END);
  localparam logic [BUFFER_BITS:0]   STEP32   = (BUFFER_BITS + 1)'(4);
  localparam logic [BUFFER_BITS:0]   STEP8    = (BUFFER_BITS + 1)'(1);

  seqState_t              fsm;
  logic [7:0]             divCnt;
  logic [RC_BITS-1:0]     resetCnt;
  logic                   doneFlag;
  logic                   sentFlag;

  logic                   tick;
  logic [BUFFER_BITS-1:0] limitEff;
  logic [BUFFER_BITS-1:0] baseIndex;
  logic [BUFFER_BITS:0]   nextIndex;
  logic                   lastPixel;
  logic                   reportFrame;

  assign state = fsm;

  // Next-pixel address and last-pixel decision for the pixel now finishing
  always_comb begin
    tick      = (divCnt == DIV_LAST);
    limitEff  = ({1'b0, regCtrlLimit} > END_W) ? END_W[BUFFER_BITS-1:0] : regCtrlLimit;
    baseIndex = regCtrl32bit ? {pixelIndex[BUFFER_BITS-1:2], 2'b00} : pixelIndex;
    nextIndex = {1'b0, baseIndex} + (regCtrl32bit ? STEP32 : STEP8);
    if (regCtrl32bit) begin
      lastPixel = (pixelIndex[BUFFER_BITS-1:2] == limitEff[BUFFER_BITS-1:2]);
    end else begin
      lastPixel = (pixelIndex == limitEff);
    end
    if (nextIndex > END_W) begin
      lastPixel = 1'b1;
    end
    reportFrame = regCtrlRun && tick && (fsm == stReset) && !doneFlag &&
                  (resetCnt == RC_LAST) && sentFlag;
  end

  // Prescaler, index walk and reset-period sequencing
  always_ff @(posedge clk) begin
    frameDone <= 1'b0;
    if (syncReset || !regCtrlRun) begin
      fsm             <= stReset;
      pixelIndex      <= '0;
      pixelBitIndex   <= '0;
      bitPatternIndex <= '0;
      resetCnt        <= '0;
      divCnt          <= '0;
      doneFlag        <= 1'b0;
      sentFlag        <= 1'b0;
    end else begin
      divCnt <= tick ? 8'd0 : divCnt + 8'd1;
      if (tick) begin
        case (fsm)
          stTransmit: begin
            if (bitPatternIndex != 3'd7) begin
              bitPatternIndex <= bitPatternIndex + 3'd1;
            end else begin
              bitPatternIndex <= 3'd0;
              if (pixelBitIndex != 5'd23) begin
                pixelBitIndex <= pixelBitIndex + 5'd1;
              end else begin
                pixelBitIndex <= 5'd0;
                if (lastPixel) begin
                  pixelIndex <= '0;
                  fsm        <= stReset;
                  resetCnt   <= '0;
                  sentFlag   <= 1'b1;
                end else begin
                  pixelIndex <= nextIndex[BUFFER_BITS-1:0];
                end
              end
            end
          end
          default: begin
            if (doneFlag) begin
              if (regCtrlLoop) begin
                doneFlag <= 1'b0;
                fsm      <= stTransmit;
              end
            end else if (resetCnt != RC_LAST) begin
              resetCnt <= resetCnt + 1'b1;
            end else begin
              frameDone <= sentFlag;
              if (regCtrlLoop || !sentFlag) begin
                fsm <= stTransmit;
              end else begin
                doneFlag <= 1'b1;
              end
            end
          end
        endcase
      end
    end
  end

`ifdef NEOPIXEL_FRAME_COUNTER_EN
  // Completed-frame counter, advanced alongside each frameDone pulse
  always_ff @(posedge clk) begin
    if (syncReset) begin
      frameCount <= 16'd0;
    end else if (reportFrame) begin
      frameCount <= frameCount + 16'd1;
    end
  end
`else
  assign frameCount = 16'd0;
  logic unusedReport;
  assign unusedReport = reportFrame;
`endif

endmodule

// File: tb/tb_anton_neopixel_sequencer.sv
// Testbench for anton_neopixel_sequencer: directed scenarios with literal
// timing expectations plus a randomized phase, all cross-checked every
// cycle against a slot-level behavioural model.

`ifndef ENUM_STATE_RESET
`define ENUM_STATE_RESET 1'b0
`endif
`ifndef ENUM_STATE_TRANSMIT
`define ENUM_STATE_TRANSMIT 1'b1
`endif

module tb_anton_neopixel_sequencer;

  localparam int BE   = 10;
  localparam int DIV  = 2;
  localparam int RT   = 4;
  localparam int BB   = $clog2(BE + 1);
  localparam logic TX = `ENUM_STATE_TRANSMIT;
  localparam logic RS = `ENUM_STATE_RESET;
`ifdef NEOPIXEL_FRAME_COUNTER_EN
  localparam bit FC_EN = 1'b1;
`else
  localparam bit FC_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          syncReset;
  logic          regCtrlRun;
  logic          regCtrlLoop;
  logic          regCtrl32bit;
  logic [BB-1:0] regCtrlLimit;
  logic          state;
  logic [BB-1:0] pixelIndex;
  logic [4:0]    pixelBitIndex;
  logic [2:0]    bitPatternIndex;
  logic          frameDone;
  logic [15:0]   frameCount;

  int vectors = 0;
  int miscompares = 0;
  bit checkEn = 1'b0;

  anton_neopixel_sequencer #(
    .BUFFER_END(BE), .CLK_DIVIDER(DIV), .RESET_TICKS(RT)
  ) dut (
    .clk(clk), .syncReset(syncReset), .regCtrlRun(regCtrlRun),
    .regCtrlLoop(regCtrlLoop), .regCtrl32bit(regCtrl32bit),
    .regCtrlLimit(regCtrlLimit), .state(state), .pixelIndex(pixelIndex),
    .pixelBitIndex(pixelBitIndex), .bitPatternIndex(bitPatternIndex),
    .frameDone(frameDone), .frameCount(frameCount)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: a frame is a list of pixels, each 192 slots long (24 bits x 8
  // patterns); the reset gap is RT slots; a slot lasts DIV clocks.
  bit mTx, mSent, mParked, mDone;
  int mPix, mSlot, mRst, mPhase, mCount;

  task automatic modelFinishPixel();
    int lim, nxt;
    bit last;
    lim = (int'(regCtrlLimit) > BE) ? BE : int'(regCtrlLimit);
    if (regCtrl32bit) begin
      last = (mPix / 4) == (lim / 4);
      nxt  = (mPix / 4) * 4 + 4;
    end else begin
      last = (mPix == lim);
      nxt  = mPix + 1;
    end
    if (nxt > BE) last = 1'b1;
    if (last) begin
      mPix = 0; mTx = 1'b0; mRst = 0; mSent = 1'b1;
    end else begin
      mPix = nxt;
    end
  endtask

  always @(posedge clk) begin
    mDone = 1'b0;
    if (syncReset === 1'b1) begin
      mTx = 0; mPix = 0; mSlot = 0; mRst = 0; mPhase = 0;
      mSent = 0; mParked = 0; mCount = 0;
    end else if (regCtrlRun !== 1'b1) begin
      mTx = 0; mPix = 0; mSlot = 0; mRst = 0; mPhase = 0;
      mSent = 0; mParked = 0;
    end else if (mPhase == DIV - 1) begin
      mPhase = 0;
      if (mTx) begin
        mSlot++;
        if (mSlot == 192) begin
          mSlot = 0;
          modelFinishPixel();
        end
      end else if (mParked) begin
        if (regCtrlLoop) begin mParked = 0; mTx = 1; end
      end else if (mRst < RT - 1) begin
        mRst++;
      end else begin
        if (mSent) begin
          mDone = 1'b1;
          if (FC_EN) mCount = (mCount + 1) % 65536;
        end
        if (regCtrlLoop || !mSent) mTx = 1'b1;
        else mParked = 1'b1;
      end
    end else begin
      mPhase++;
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("state", state, mTx ? TX : RS);
      checkOutput("pixelIndex", pixelIndex, mPix);
      checkOutput("pixelBitIndex", pixelBitIndex, mSlot / 8);
      checkOutput("bitPatternIndex", bitPatternIndex, mSlot % 8);
      checkOutput("frameDone", frameDone, mDone);
      checkOutput("frameCount", frameCount, mCount);
    end
  end

  task automatic applyStimulus(input logic run, input logic loop,
                               input logic wide, input logic [BB-1:0] limit);
    @(negedge clk);
    regCtrlRun = run; regCtrlLoop = loop; regCtrl32bit = wide; regCtrlLimit = limit;
  endtask

  task automatic clocksUntilState(input logic target, input int bound, output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (state !== target && n < bound);
  endtask

  task automatic clocksUntilDone(input int bound, output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (frameDone !== 1'b1 && n < bound);
  endtask

  // Runs one transmit burst, recording distinct pixel addresses in order
  task automatic collectFrame(output int pix[$], output int n);
    pix.delete();
    n = 0;
    while (state === TX && n < 6000) begin
      if (pix.size() == 0 || pix[$] != int'(pixelIndex)) pix.push_back(int'(pixelIndex));
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int n, pulses, txSeen, maxPix;
    int pix[$];
    syncReset = 1; regCtrlRun = 0; regCtrlLoop = 0; regCtrl32bit = 0; regCtrlLimit = '0;
    repeat (3) @(negedge clk);
    syncReset = 0;
    checkEn = 1;
    checkOutput("resetState", state, RS);
    checkOutput("resetPixel", pixelIndex, 0);

    // 8-bit single frame, limit 2
    applyStimulus(1, 0, 0, 2);
    clocksUntilState(TX, 100, n);
    checkOutput("firstResetClocks", n, 8);
    collectFrame(pix, n);
    checkOutput("frame8Clocks", n, 1152);
    checkOutput("frame8Pixels", pix.size(), 3);
    for (int i = 0; i < 3 && i < pix.size(); i++) checkOutput("frame8Seq", pix[i], i);
    clocksUntilDone(100, n);
    checkOutput("doneAfterReset", n, 8);
    pulses = 0; txSeen = 0;
    repeat (1500) begin
      @(negedge clk);
      if (frameDone === 1'b1) pulses++;
      if (state === TX) txSeen++;
    end
    checkOutput("noSecondDone", pulses, 0);
    checkOutput("noSecondFrame", txSeen, 0);

    // 32-bit single frame, limit 11
    applyStimulus(0, 0, 1, 11);
    applyStimulus(1, 0, 1, 11);
    clocksUntilState(TX, 100, n);
    collectFrame(pix, n);
    checkOutput("frame32Pixels", pix.size(), 3);
    for (int i = 0; i < 3 && i < pix.size(); i++) checkOutput("frame32Seq", pix[i], 4 * i);

    // Looping frames from a fresh reset
    @(negedge clk); syncReset = 1; regCtrlRun = 0;
    applyStimulus(1, 1, 0, 2);
    syncReset = 0;
    clocksUntilDone(3000, n);
    checkOutput("loopFirstDone", frameDone, 1);
    checkOutput("loopCount1", frameCount, FC_EN ? 1 : 0);
    clocksUntilDone(3000, n);
    checkOutput("loopGap", n, 1160);
    checkOutput("loopCount2", frameCount, FC_EN ? 2 : 0);
    repeat (3) clocksUntilDone(3000, n);
    checkOutput("loopCount5", frameCount, FC_EN ? 5 : 0);
    checkOutput("loopRestart", state, TX);
    @(negedge clk); syncReset = 1;
    @(negedge clk);
    checkOutput("syncResetState", state, RS);
    checkOutput("syncResetCount", frameCount, 0);
    checkOutput("syncResetBit", pixelBitIndex, 0);
    syncReset = 0;

    // Abort mid-pixel, then restart
    n = 0;
    while (!(state === TX && pixelIndex == 1 && pixelBitIndex == 10) && n < 3000) begin
      @(negedge clk); n++;
    end
    checkOutput("abortPoint", pixelBitIndex, 10);
    regCtrlRun = 0;
    @(negedge clk);
    checkOutput("abortState", state, RS);
    checkOutput("abortPixel", pixelIndex, 0);
    checkOutput("abortPattern", bitPatternIndex, 0);
    regCtrlRun = 1;
    clocksUntilState(TX, 100, n);
    checkOutput("restartResetClocks", n, 8);
    checkOutput("restartPixel", pixelIndex, 0);

    // Limit beyond the buffer end is clamped
    applyStimulus(0, 0, 0, 15);
    applyStimulus(1, 0, 0, 15);
    clocksUntilState(TX, 100, n);
    collectFrame(pix, n);
    maxPix = 0;
    foreach (pix[i]) if (pix[i] > maxPix) maxPix = pix[i];
    checkOutput("clampPixels", pix.size(), BE + 1);
    checkOutput("clampMax", maxPix, BE);

    // Randomized control activity checked by the model
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      syncReset = ($urandom_range(0, 1999) == 0);
      if ($urandom_range(0, 299) == 0) regCtrlRun = ~regCtrlRun;
      if ($urandom_range(0, 399) == 0) regCtrlLoop = ~regCtrlLoop;
      if ($urandom_range(0, 199) == 0) regCtrl32bit = ~regCtrl32bit;
      if ($urandom_range(0, 149) == 0) regCtrlLimit = BB'($urandom_range(0, 15));
      if (i < 200) regCtrlRun = 1;
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
